forward_arbiter: RTL and testbench

Per-slave request arbiter of the crossbar: selects which master interface may forward its front AR or AW entry into this slave's address FIFO. It drives the grant number and push-to-fifo strobe that every master interface compares against its own number before popping. When used for the write-address channel, it also records the order of granted masters so that the slave side routes W beats from the correct master.

---
 rtl/xbar_pkg.sv | 17 +
 rtl/grant_order_fifo.sv | 57 +++++
 rtl/forward_arbiter.sv | 111 +++++++++++
 tb/tb_forward_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar helpers: id widths and the idle grant code.
package xbar_pkg;

  function automatic int unsigned mid_w(input int unsigned masters);
    return (masters < 2) ? 1 : $clog2(masters);
  endfunction

  function automatic int unsigned sid_w(input int unsigned slaves);
    return (slaves < 2) ? 1 : $clog2(slaves);
  endfunction

  // Idle grant sits one bit above any valid master number.
  function automatic int unsigned grant_idle(input int unsigned masters);
    return 32'(1) << mid_w(masters);
  endfunction

endpackage

// File: rtl/grant_order_fifo.sv
// Grant-order queue: remembers which master owns each accepted AW so W beats follow in order.
module grant_order_fifo #(
  parameter int unsigned depth = 8,
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags come from the registered count only, so a full queue blocks push even with a pop.
  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/forward_arbiter.sv
// Per-slave round-robin arbiter selecting which master forwards its front AR/AW entry,
// with an optional grant-order queue for W routing.
module forward_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned masters           = 2,
  parameter int unsigned slaves            = 2,
  parameter int unsigned i_am_slave_number = 0,
  parameter int unsigned track_order       = 0,
  parameter int unsigned pending_depth     = 8,
  localparam int unsigned MID_W            = mid_w(masters),
  localparam int unsigned SID_W            = sid_w(slaves),
  localparam int unsigned GNT_W            = MID_W + 1
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             master_fifo_empty [0:masters-1],
  input  logic [SID_W-1:0] master_dest_slave [0:masters-1],
  input  logic             slave_fifo_full,
  output logic [GNT_W-1:0] grant_master_number,
  output logic             push_to_fifo,
  output logic [MID_W-1:0] order_front_master,
  output logic             order_valid,
  input  logic             order_pop
);

  logic [masters-1:0] req;
  logic               cand_found;
  logic [MID_W-1:0]   cand;
  logic [MID_W-1:0]   grant_num;
  logic [MID_W-1:0]   rr_ptr;
  logic [MID_W-1:0]   lock_master;
  logic               lock_valid;
  logic               lock_hold;
  logic               grant_valid;
  logic               order_full;
  int unsigned        idx;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < masters; i++)
      req[i] = ~master_fifo_empty[i] & (master_dest_slave[i] == SID_W'(i_am_slave_number));
  end

  // First requester at or after rr_ptr, wrapping modulo masters.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    idx        = 0;
    for (int unsigned off = 0; off < masters; off++) begin
      idx = (32'(rr_ptr) + off) % masters;
      if (!cand_found && req[MID_W'(idx)]) begin
        cand_found = 1'b1;
        cand       = MID_W'(idx);
      end
    end
  end

  // A stalled grant stays locked while its master keeps requesting.
  assign lock_hold   = lock_valid & req[lock_master];
  assign grant_num   = lock_hold ? lock_master : cand;
  assign grant_valid = ARESETn & cand_found;

  assign grant_master_number = grant_valid ? {1'b0, grant_num} : GNT_W'(grant_idle(masters));
  assign push_to_fifo        = grant_valid & ~slave_fifo_full & ~order_full;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_ptr      <= '0;
      lock_valid  <= 1'b0;
      lock_master <= '0;
    end else if (push_to_fifo) begin
      rr_ptr     <= (grant_num == MID_W'(masters - 1)) ? '0 : grant_num + MID_W'(1);
      lock_valid <= 1'b0;
    end else if (grant_valid) begin
      lock_valid  <= 1'b1;
      lock_master <= grant_num;
    end else begin
      lock_valid <= 1'b0;
    end
  end

  if (track_order != 0) begin : g_order
    logic [MID_W-1:0] head;
    logic             empty;

    grant_order_fifo #(
      .depth (pending_depth),
      .width (MID_W)
    ) u_order_fifo (
      .clk   (ACLK),
      .rst_n (ARESETn),
      .push  (push_to_fifo),
      .pop   (order_pop),
      .din   (grant_num),
      .dout  (head),
      .full  (order_full),
      .empty (empty)
    );

    assign order_valid        = ~empty;
    assign order_front_master = empty ? '0 : head;
  end else begin : g_no_order
    logic unused_pop;
    assign unused_pop         = order_pop;
    assign order_full         = 1'b0;
    assign order_valid        = 1'b0;
    assign order_front_master = '0;
  end

endmodule

// File: tb/tb_forward_arbiter.sv
// Randomized + directed bench for forward_arbiter: an AW instance (order tracking) and an
// AR instance share inputs and are compared against a queue-based reference model.
module tb_forward_arbiter;

  localparam int M = 2;
  localparam int D = 8;
  localparam int IDLE = 2;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic       master_fifo_empty [0:M-1];
  logic [0:0] master_dest_slave [0:M-1];
  logic       slave_fifo_full;
  logic       order_pop;

  logic [1:0] aw_grant, ar_grant;
  logic       aw_push, ar_push;
  logic [0:0] aw_front, ar_front;
  logic       aw_valid, ar_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: index 0 = AR instance, 1 = AW instance.
  int rr     [2];
  int lock_m [2];
  bit lock_v [2];
  int q [$];

  always #5 ACLK = ~ACLK;

  forward_arbiter #(
    .masters(2), .slaves(2), .i_am_slave_number(0), .track_order(1), .pending_depth(D)
  ) u_aw (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .master_fifo_empty(master_fifo_empty), .master_dest_slave(master_dest_slave),
    .slave_fifo_full(slave_fifo_full),
    .grant_master_number(aw_grant), .push_to_fifo(aw_push),
    .order_front_master(aw_front), .order_valid(aw_valid), .order_pop(order_pop)
  );

  forward_arbiter #(
    .masters(2), .slaves(2), .i_am_slave_number(0), .track_order(0), .pending_depth(D)
  ) u_ar (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .master_fifo_empty(master_fifo_empty), .master_dest_slave(master_dest_slave),
    .slave_fifo_full(slave_fifo_full),
    .grant_master_number(ar_grant), .push_to_fifo(ar_push),
    .order_front_master(ar_front), .order_valid(ar_valid), .order_pop(order_pop)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit e0, input bit d0, input bit e1, input bit d1,
                        input bit full, input bit pop);
    master_fifo_empty[0] = e0;
    master_dest_slave[0] = d0;
    master_fifo_empty[1] = e1;
    master_dest_slave[1] = d1;
    slave_fifo_full      = full;
    order_pop            = pop;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rr[k] = 0;
      lock_m[k] = 0;
      lock_v[k] = 0;
    end
    q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_aw_gnt"}, int'(aw_grant), IDLE);
    check({tag, "_aw_push"}, int'(aw_push), 0);
    check({tag, "_aw_valid"}, int'(aw_valid), 0);
    check({tag, "_aw_front"}, int'(aw_front), 0);
    check({tag, "_ar_gnt"}, int'(ar_grant), IDLE);
    check({tag, "_ar_push"}, int'(ar_push), 0);
  endtask

  // Called just after a negedge with inputs applied; checks, advances model, waits a cycle.
  task automatic cycle(input string tag);
    bit req [M];
    bit any;
    int g [2];
    bit pu [2];
    int pos;
    any = 0;
    for (int i = 0; i < M; i++) begin
      req[i] = !master_fifo_empty[i] && (master_dest_slave[i] == 1'b0);
      any = any | req[i];
    end
    for (int k = 0; k < 2; k++) begin
      g[k] = 0;
      if (lock_v[k] && req[lock_m[k]]) begin
        g[k] = lock_m[k];
      end else begin
        for (int off = M - 1; off >= 0; off--) begin
          pos = (rr[k] + off) % M;
          if (req[pos]) g[k] = pos;
        end
      end
      pu[k] = any && !slave_fifo_full && !(k == 1 && q.size() == D);
    end
    #1;
    check({tag, "_aw_gnt"}, int'(aw_grant), any ? g[1] : IDLE);
    check({tag, "_aw_push"}, int'(aw_push), int'(pu[1]));
    check({tag, "_aw_valid"}, int'(aw_valid), (q.size() != 0) ? 1 : 0);
    check({tag, "_aw_front"}, int'(aw_front), (q.size() != 0) ? q[0] : 0);
    check({tag, "_ar_gnt"}, int'(ar_grant), any ? g[0] : IDLE);
    check({tag, "_ar_push"}, int'(ar_push), int'(pu[0]));
    check({tag, "_ar_valid"}, int'(ar_valid), 0);
    check({tag, "_ar_front"}, int'(ar_front), 0);
    for (int k = 0; k < 2; k++) begin
      if (pu[k]) begin
        rr[k] = (g[k] + 1) % M;
        lock_v[k] = 0;
      end else if (any) begin
        lock_v[k] = 1;
        lock_m[k] = g[k];
      end else begin
        lock_v[k] = 0;
      end
    end
    if (order_pop && q.size() != 0) void'(q.pop_front());
    if (pu[1]) q.push_back(g[1]);
    @(negedge ACLK);
  endtask

  initial begin
    set_in(1, 0, 1, 0, 0, 0);
    ARESETn = 1'b0;
    model_reset();
    @(negedge ACLK);
    #1;
    check_reset_outputs("rst");
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Both masters target slave 0: strict alternation, push every cycle.
    set_in(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_gnt", int'(ar_grant), i % 2);
      check("alt_push", int'(ar_push), 1);
      if (i == 1) check("pushpop_empty_valid", int'(aw_valid), 1);
      cycle("alt");
    end

    // Master 1 granted under back-pressure stays granted until the push.
    cycle("pre_hold");
    set_in(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_gnt", int'(ar_grant), 1);
      check("hold_push", int'(ar_push), 0);
      cycle("hold");
    end
    set_in(0, 0, 0, 0, 0, 1);
    #1;
    check("release_gnt", int'(ar_grant), 1);
    check("release_push", int'(ar_push), 1);
    cycle("release");
    #1;
    check("after_release_gnt", int'(ar_grant), 0);
    cycle("after_release");

    // Request aimed at another slave only.
    set_in(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("other_slave_gnt", int'(ar_grant), IDLE);
      check("other_slave_push", int'(aw_push), 0);
      cycle("other_slave");
    end

    // Asynchronous reset while requests are active.
    set_in(0, 0, 0, 0, 0, 0);
    #3;
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Fill the order queue, then a single pop frees a slot for the next cycle.
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < D; i++) cycle("fill");
    #1;
    check("qfull_aw_push", int'(aw_push), 0);
    check("qfull_ar_push", int'(ar_push), 1);
    cycle("qfull");
    set_in(0, 0, 0, 0, 0, 1);
    #1;
    check("qfull_pop_push", int'(aw_push), 0);
    cycle("qfull_pop");
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    check("qresume_push", int'(aw_push), 1);
    check("qresume_front", int'(aw_front), 1);
    cycle("qresume");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(99) < 30, $urandom_range(99) < 25,
             $urandom_range(99) < 30, $urandom_range(99) < 25,
             $urandom_range(99) < 25, $urandom_range(99) < 45);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
